// File: rtl/pwm_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_sweep_ctrl
//  Purpose  : Sequencer for a two-channel PWM sweep. An internal prescaler
//             produces the step tick. A phase counter walks 0..2*HALF-1. The
//             high-side duty ramps during the first half of the sweep and the
//             low-side duty ramps during the second half. Each duty is compared
//             against a free-running carrier to drive the registered PWM pins.
//  Ports    : clk        - system clock
//             rst        - synchronous, active-high reset
//             start      - 1-cycle pulse, begin a sweep (ignored while busy)
//             stop       - 1-cycle pulse, abort a sweep (wins over start)
//             mode_cont  - 1 = restart after each sweep, sampled at sweep end
//             busy       - high while a sweep is running
//             phase[8:0] - current step
//             duty_h/l   - high/low-side duty compare values
//             pwm_h/l    - registered PWM outputs
//             sweep_done - 1-cycle pulse when the last step completes
//  Revision : 1.0  initial release
// ============================================================================
module pwm_sweep_ctrl #(
    parameter int PRESCALE    = 16,
    parameter int HALF        = 180,
    parameter int CARRIER_TOP = 179
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       mode_cont,
    output logic       busy,
    output logic [8:0] phase,
    output logic [7:0] duty_h,
    output logic [7:0] duty_l,
    output logic       pwm_h,
    output logic       pwm_l,
    output logic       sweep_done
);

    localparam int c_presc_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(PRESCALE - 1);
    localparam logic [8:0]           c_half       = 9'(HALF);
    localparam logic [8:0]           c_half_last  = 9'(HALF - 1);
    localparam logic [8:0]           c_full_last  = 9'(2 * HALF - 1);
    localparam logic [7:0]           c_car_top    = 8'(CARRIER_TOP);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN_H = 2'd1;
    localparam logic [1:0] S_RUN_L = 2'd2;

    logic [1:0]           r_state;
    logic [c_presc_w-1:0] r_presc;
    logic [7:0]           r_carrier;
    logic                 r_busy;
    logic [8:0]           r_phase;
    logic [7:0]           r_duty_h;
    logic [7:0]           r_duty_l;
    logic                 r_pwm_h;
    logic                 r_pwm_l;
    logic                 r_done;

    logic [1:0]           w_state_nxt;
    logic [c_presc_w-1:0] w_presc_nxt;
    logic [7:0]           w_carrier_nxt;
    logic [8:0]           w_phase_nxt;
    logic [7:0]           w_duty_h_nxt;
    logic [7:0]           w_duty_l_nxt;
    logic                 w_done_nxt;
    logic                 w_run_nxt;
    logic                 w_tick;

    assign w_tick = r_busy && (r_presc == c_presc_last);

    // Next-state and next-phase selection
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_presc_nxt = '0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_phase_nxt = '0;
                if (start && !stop) begin
                    w_state_nxt = S_RUN_H;
                end
            end
            S_RUN_H: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                    w_phase_nxt = '0;
                end else begin
                    w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
                    if (w_tick) begin
                        if (r_phase == c_half_last) begin
                            w_state_nxt = S_RUN_L;
                            w_phase_nxt = c_half;
                        end else begin
                            w_phase_nxt = r_phase + 9'd1;
                        end
                    end
                end
            end
            S_RUN_L: begin
                // stop is tested first so that it also suppresses a final tick
                if (stop) begin
                    w_state_nxt = S_IDLE;
                    w_phase_nxt = '0;
                end else begin
                    w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
                    if (w_tick) begin
                        if (r_phase == c_full_last) begin
                            w_state_nxt = mode_cont ? S_RUN_H : S_IDLE;
                            w_phase_nxt = '0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_phase_nxt = r_phase + 9'd1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_phase_nxt = '0;
            end
        endcase
    end

    // Duties follow the phase being loaded, so they change on the same edge
    always_comb begin
        w_run_nxt     = (w_state_nxt != S_IDLE);
        w_duty_h_nxt  = (w_state_nxt == S_RUN_H) ? w_phase_nxt[7:0] : 8'd0;
        w_duty_l_nxt  = (w_state_nxt == S_RUN_L) ? 8'(w_phase_nxt - c_half) : 8'd0;
        w_carrier_nxt = 8'd0;
        if (w_run_nxt && r_busy) begin
            w_carrier_nxt = (r_carrier == c_car_top) ? 8'd0 : r_carrier + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_carrier <= '0;
            r_busy    <= 1'b0;
            r_phase   <= '0;
            r_duty_h  <= '0;
            r_duty_l  <= '0;
            r_pwm_h   <= 1'b0;
            r_pwm_l   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_carrier <= w_carrier_nxt;
            r_busy    <= w_run_nxt;
            r_phase   <= w_phase_nxt;
            r_duty_h  <= w_duty_h_nxt;
            r_duty_l  <= w_duty_l_nxt;
            // Compare uses the current carrier and duty, giving one cycle of lag
            r_pwm_h   <= w_run_nxt && r_busy && (r_carrier < r_duty_h);
            r_pwm_l   <= w_run_nxt && r_busy && (r_carrier < r_duty_l);
            r_done    <= w_done_nxt;
        end
    end

    assign busy       = r_busy;
    assign phase      = r_phase;
    assign duty_h     = r_duty_h;
    assign duty_l     = r_duty_l;
    assign pwm_h      = r_pwm_h;
    assign pwm_l      = r_pwm_l;
    assign sweep_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pwm_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_sweep_ctrl
//  Purpose  : Directed self-checking bench for pwm_sweep_ctrl. The main
//             instance uses PRESCALE=2, HALF=4 and CARRIER_TOP=3. A second
//             instance with PRESCALE=8 holds each duty long enough to observe
//             a full carrier period.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pwm_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode_cont = 1'b0;
    logic       busy;
    logic [8:0] phase;
    logic [7:0] duty_h;
    logic [7:0] duty_l;
    logic       pwm_h;
    logic       pwm_l;
    logic       sweep_done;

    logic       start2 = 1'b0;
    logic       stop2 = 1'b0;
    logic       busy2;
    logic [8:0] phase2;
    logic [7:0] duty_h2;
    logic [7:0] duty_l2;
    logic       pwm_h2;
    logic       pwm_l2;
    logic       done2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pwm_sweep_ctrl #(.PRESCALE(2), .HALF(4), .CARRIER_TOP(3)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode_cont(mode_cont),
        .busy(busy), .phase(phase), .duty_h(duty_h), .duty_l(duty_l),
        .pwm_h(pwm_h), .pwm_l(pwm_l), .sweep_done(sweep_done)
    );

    pwm_sweep_ctrl #(.PRESCALE(8), .HALF(4), .CARRIER_TOP(3)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .stop(stop2), .mode_cont(1'b0),
        .busy(busy2), .phase(phase2), .duty_h(duty_h2), .duty_l(duty_l2),
        .pwm_h(pwm_h2), .pwm_l(pwm_l2), .sweep_done(done2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Advance one clock; outputs are read 1 ns after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, " busy"}, 32'(busy), 0);
        check_eq({tag, " phase"}, 32'(phase), 0);
        check_eq({tag, " duty_h"}, 32'(duty_h), 0);
        check_eq({tag, " duty_l"}, 32'(duty_l), 0);
        check_eq({tag, " pwm"}, 32'({pwm_h, pwm_l}), 0);
        check_eq({tag, " done"}, 32'(sweep_done), 0);
    endtask

    // One-shot sweep; sample k is taken after the k-th edge following busy rise
    task automatic run_sweep(input string tn, input bit poke_start);
        int p;
        int eh;
        int el;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            p  = (k < 16) ? k / 2 : 0;
            eh = (k < 16 && p < 4) ? p : 0;
            el = (k < 16 && p >= 4) ? p - 4 : 0;
            check_eq($sformatf("%s phase k=%0d", tn, k), 32'(phase), 32'(p));
            check_eq($sformatf("%s busy k=%0d", tn, k), 32'(busy), (k < 16) ? 1 : 0);
            check_eq($sformatf("%s done k=%0d", tn, k), 32'(sweep_done), (k == 16) ? 1 : 0);
            check_eq($sformatf("%s duty_h k=%0d", tn, k), 32'(duty_h), 32'(eh));
            check_eq($sformatf("%s duty_l k=%0d", tn, k), 32'(duty_l), 32'(el));
            check_eq($sformatf("%s pwm_excl k=%0d", tn, k), 32'(pwm_h & pwm_l), 0);
            start = (poke_start && (k == 3 || k == 9)) ? 1'b1 : 1'b0;
            if (k < 16) cyc();
        end
        start = 1'b0;
        cyc();
        check_idle({tn, " after"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_seen;
        int waited;

        // 1. reset with start held, then idle
        rst = 1'b1; start = 1'b1;
        cyc(); cyc();
        check_idle("t1 reset");
        rst = 1'b0; start = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (busy) busy_seen++;
        end
        check_eq("t1 idle busy count", 32'(busy_seen), 0);

        // 2. one-shot sweep
        mode_cont = 1'b0;
        run_sweep("t2", 1'b0);

        // 3. PWM compare on the slow instance
        start2 = 1'b1;
        cyc();
        start2 = 1'b0;
        waited = 0;
        while (duty_h2 != 8'd2 && waited < 40) begin
            cyc();
            waited++;
        end
        check_eq("t3 reach duty2 edge", 32'(waited), 16);
        check_eq("t3 pwm_h at duty step", 32'(pwm_h2), 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_eq($sformatf("t3 pwm_h i=%0d", i), 32'(pwm_h2), (i < 2) ? 1 : 0);
            check_eq($sformatf("t3 pwm_l i=%0d", i), 32'(pwm_l2), 0);
            check_eq($sformatf("t3 duty_h i=%0d", i), 32'(duty_h2), 2);
        end
        stop2 = 1'b1;
        cyc();
        stop2 = 1'b0;
        check_eq("t3 stop busy2", 32'(busy2), 0);
        check_eq("t3 stop pwm2", 32'({pwm_h2, pwm_l2}), 0);
        check_eq("t3 stop done2", 32'(done2), 0);

        // 4. continuous mode, cleared during the third sweep
        mode_cont = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k <= 48; k++) begin
            check_eq($sformatf("t4 done k=%0d", k), 32'(sweep_done),
                     (k == 16 || k == 32 || k == 48) ? 1 : 0);
            check_eq($sformatf("t4 busy k=%0d", k), 32'(busy), (k < 48) ? 1 : 0);
            check_eq($sformatf("t4 phase k=%0d", k), 32'(phase),
                     (k < 48) ? 32'((k % 16) / 2) : 0);
            if (k == 40) mode_cont = 1'b0;
            if (k < 48) cyc();
        end
        cyc();
        check_idle("t4 after");

        // 5a. stop at phase 5
        run_stop_at(10, "t5a");
        // 5b. stop together with the final tick
        run_stop_at(15, "t5b");

        // 5c. start and stop together while idle
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        check_eq("t5c busy", 32'(busy), 0);
        cyc(); cyc();
        check_eq("t5c busy later", 32'(busy), 0);

        // 5d. start while busy is ignored
        run_sweep("t5d", 1'b1);

        // 6. reset mid-sweep, then restart
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 5; k++) cyc();
        check_eq("t6 phase before rst", 32'(phase), 2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_idle("t6 rst");
        cyc();
        check_idle("t6 post rst");
        start = 1'b1;
        cyc();
        start = 1'b0;
        check_eq("t6 restart busy", 32'(busy), 1);
        check_eq("t6 restart phase k0", 32'(phase), 0);
        cyc();
        check_eq("t6 restart phase k1", 32'(phase), 0);
        cyc();
        check_eq("t6 restart phase k2", 32'(phase), 1);
        check_eq("t6 restart duty_h k2", 32'(duty_h), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Start a one-shot sweep and pulse stop after sample k_stop
    task automatic run_stop_at(input int k_stop, input string tn);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < k_stop; k++) cyc();
        check_eq({tn, " busy before stop"}, 32'(busy), 1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check_idle({tn, " stopped"});
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_eq($sformatf("%s quiet done i=%0d", tn, i), 32'(sweep_done), 0);
            check_eq($sformatf("%s quiet busy i=%0d", tn, i), 32'(busy), 0);
        end
    endtask

endmodule
`default_nettype wire
